// File: rtl/console_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// console_ctrl_pkg : shared character codes, geometry defaults, FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
package console_ctrl_pkg;

    localparam int COLS_DEF   = 80;
    localparam int ROWS_DEF   = 30;
    localparam int ADDR_W_DEF = 14;

    localparam logic [7:0] CH_SPACE    = 8'h20;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_PRINT_LO) && (c <= CH_PRINT_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/console_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// console_ctrl_if : byte-stream inputs and framebuffer write port
// Rev 1.0
// ----------------------------------------------------------------------------
interface console_ctrl_if #(
    parameter int ADDR_W = 14
) ();
    logic [7:0]        src0_data;
    logic              src0_valid;
    logic              src0_ready;
    logic [7:0]        src1_data;
    logic              src1_valid;
    logic              src1_ready;
    logic [ADDR_W-1:0] fb_waddr;
    logic [7:0]        fb_wdata;
    logic              fb_wr_en;
    logic [ADDR_W-1:0] cursor_addr;
    logic              busy;

    modport slave (
        input  src0_data, src0_valid, src1_data, src1_valid,
        output src0_ready, src1_ready, fb_waddr, fb_wdata, fb_wr_en,
               cursor_addr, busy
    );

    modport master (
        output src0_data, src0_valid, src1_data, src1_valid,
        input  src0_ready, src1_ready, fb_waddr, fb_wdata, fb_wr_en,
               cursor_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/console_ctrl_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arb2 : two-way round-robin arbiter, grant one-hot or zero
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       enable,
    output logic [1:0] grant
);
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance) last_grant_d = grant[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_grant_q <= 1'b1;
        else        last_grant_q <= last_grant_d;
    end
endmodule
`default_nettype wire

// File: rtl/console_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// console_ctrl : text console, arbitrates two byte streams into the framebuffer
// Rev 1.0
// ----------------------------------------------------------------------------
module console_ctrl
    import console_ctrl_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic          clk48,
    input  logic          rst_n,
    console_ctrl_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CLR_W = $clog2(ROWS * COLS);

    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST      = ROW_W'(ROWS - 1);
    localparam logic [CLR_W-1:0]  CLR_INIT_LAST = CLR_W'(ROWS * COLS - 1);
    localparam logic [CLR_W-1:0]  CLR_ROW_LAST  = CLR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP      = ADDR_W'(COLS);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  row_base_q, row_base_d;
    logic [CLR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [7:0]         byte_q, byte_d;

    logic [1:0]         grant;
    logic               accept;
    logic [ADDR_W-1:0]  cursor;
    logic               wr_en;
    logic [ADDR_W-1:0]  waddr;
    logic [7:0]         wdata;
    logic               row_adv;

    assign accept = (bus.src0_valid & bus.src0_ready) | (bus.src1_valid & bus.src1_ready);
    assign cursor = row_base_q + ADDR_W'(col_q);

    rr_arb2 u_arb (
        .clk     (clk48),
        .rst_n   (rst_n),
        .req     ({bus.src1_valid, bus.src0_valid}),
        .advance (accept),
        .enable  (state_q == ST_IDLE),
        .grant   (grant)
    );

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        clr_cnt_d  = clr_cnt_q;
        byte_d     = byte_q;
        wr_en      = 1'b0;
        waddr      = '0;
        wdata      = '0;
        row_adv    = 1'b0;

        case (state_q)
            ST_INIT: begin
                wr_en     = 1'b1;
                waddr     = ADDR_W'(clr_cnt_q);
                wdata     = CH_SPACE;
                clr_cnt_d = clr_cnt_q + CLR_W'(1);
                if (clr_cnt_q == CLR_INIT_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    byte_d  = grant[1] ? bus.src1_data : bus.src0_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                if (is_printable(byte_q)) begin
                    wr_en = 1'b1;
                    waddr = cursor;
                    wdata = byte_q;
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        row_adv = 1'b1;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end else if (byte_q == CH_LF) begin
                    col_d   = '0;
                    row_adv = 1'b1;
                end else if (byte_q == CH_CR) begin
                    col_d = '0;
                end else if ((byte_q == CH_BS) && (col_q != '0)) begin
                    // Backspace stays on the current row: no reverse wrap at col 0
                    col_d = col_q - COL_W'(1);
                    wr_en = 1'b1;
                    waddr = cursor - ADDR_W'(1);
                    wdata = CH_SPACE;
                end
            end
            ST_CLEAR: begin
                wr_en     = 1'b1;
                waddr     = row_base_q + ADDR_W'(clr_cnt_q);
                wdata     = CH_SPACE;
                clr_cnt_d = clr_cnt_q + CLR_W'(1);
                if (clr_cnt_q == CLR_ROW_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Bottom row wraps to the top and overwrites it; there is no scrolling
        if (row_adv) begin
            clr_cnt_d = '0;
            state_d   = ST_CLEAR;
            if (row_q == ROW_LAST) begin
                row_d      = '0;
                row_base_d = '0;
            end else begin
                row_d      = row_q + ROW_W'(1);
                row_base_d = row_base_q + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            clr_cnt_q  <= '0;
            byte_q     <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            clr_cnt_q  <= clr_cnt_d;
            byte_q     <= byte_d;
        end
    end

    // Outputs are gated by rst_n so a reset kills a write strobe without a clock edge
    assign bus.src0_ready  = grant[0] & rst_n;
    assign bus.src1_ready  = grant[1] & rst_n;
    assign bus.fb_wr_en    = wr_en & rst_n;
    assign bus.fb_waddr    = rst_n ? waddr  : '0;
    assign bus.fb_wdata    = rst_n ? wdata  : '0;
    assign bus.cursor_addr = rst_n ? cursor : '0;
    assign bus.busy        = (state_q == ST_INIT) || (state_q == ST_CLEAR);
endmodule
`default_nettype wire

// File: tb/tb_console_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_console_ctrl : directed vectors and corner-case sequences for console_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_console_ctrl;
    logic clk48 = 1'b0;
    logic rst_n = 1'b0;

    console_ctrl_if #(.ADDR_W(14)) bus ();

    console_ctrl #(.COLS(80), .ROWS(30), .ADDR_W(14)) dut (
        .clk48 (clk48),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk48 = ~clk48;

    typedef struct packed { logic [13:0] a; logic [7:0] d; } wr_t;
    typedef struct packed { logic s; logic [7:0] d; } acc_t;
    typedef struct {
        logic [7:0]  ch;
        logic        wr;
        logic [13:0] addr;
        logic [7:0]  data;
        logic [13:0] cur;
    } vec_t;

    wr_t  wlog[$];
    acc_t alog[$];
    int   nchk = 0;
    int   nerr = 0;
    int   both_rdy = 0;
    int   busy_rdy = 0;

    always @(negedge clk48) begin
        if (bus.fb_wr_en) wlog.push_back({bus.fb_waddr, bus.fb_wdata});
        if (bus.src0_ready && bus.src1_ready) both_rdy++;
        if (bus.busy && (bus.src0_ready || bus.src1_ready)) busy_rdy++;
        if (bus.src0_valid && bus.src0_ready) alog.push_back({1'b0, bus.src0_data});
        if (bus.src1_valid && bus.src1_ready) alog.push_back({1'b1, bus.src1_data});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Presents one byte and returns #1 after the accepting edge (DUT in EXEC)
    task automatic send(input int src, input logic [7:0] b);
        int n = 0;
        if (src == 0) begin bus.src0_data = b; bus.src0_valid = 1'b1; end
        else          begin bus.src1_data = b; bus.src1_valid = 1'b1; end
        #1;
        while (!((src == 0) ? bus.src0_ready : bus.src1_ready)) begin
            @(posedge clk48); #1;
            n++;
            if (n > 200) begin
                nchk++; nerr++;
                $display("FAIL send_timeout: src %0d byte %0h not accepted in %0d cycles", src, b, n);
                break;
            end
        end
        @(posedge clk48); #1;
        if (src == 0) bus.src0_valid = 1'b0;
        else          bus.src1_valid = 1'b0;
    endtask

    task automatic wait_not_busy(input int limit);
        int n = 0;
        while (bus.busy && n < limit) begin
            @(posedge clk48); #1;
            n++;
        end
        chk("busy_wait", bus.busy, 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        int bad;
        logic [7:0] ch;
        logic       s_exp;
        logic [7:0] d_exp;

        vecs[0] = '{8'h41, 1'b1, 14'd0, 8'h41, 14'd1};
        vecs[1] = '{8'h42, 1'b1, 14'd1, 8'h42, 14'd2};
        vecs[2] = '{8'h08, 1'b1, 14'd1, 8'h20, 14'd1};
        vecs[3] = '{8'h0D, 1'b0, 14'd0, 8'h00, 14'd0};
        vecs[4] = '{8'h08, 1'b0, 14'd0, 8'h00, 14'd0};
        vecs[5] = '{8'h7E, 1'b1, 14'd0, 8'h7E, 14'd1};
        vecs[6] = '{8'h7F, 1'b0, 14'd0, 8'h00, 14'd1};
        vecs[7] = '{8'h1F, 1'b0, 14'd0, 8'h00, 14'd1};
        vecs[8] = '{8'h20, 1'b1, 14'd1, 8'h20, 14'd2};

        // Reset state with both sources requesting
        bus.src0_data = 8'h00; bus.src0_valid = 1'b1;
        bus.src1_data = 8'h00; bus.src1_valid = 1'b1;
        #2;
        chk("rst_wr_en", bus.fb_wr_en, 1'b0);
        chk("rst_waddr", bus.fb_waddr, 14'd0);
        chk("rst_wdata", bus.fb_wdata, 8'h00);
        chk("rst_ready", {bus.src1_ready, bus.src0_ready}, 2'b00);
        chk("rst_cursor", bus.cursor_addr, 14'd0);
        chk("rst_busy", bus.busy, 1'b1);

        // INIT: src0 holds a dropped code so readys are exercised during busy
        bus.src1_valid = 1'b0;
        @(posedge clk48); #1;
        wlog.delete();
        rst_n = 1'b1;
        wait_not_busy(3000);
        chk("init_count", wlog.size(), 2400);
        bad = 0;
        foreach (wlog[i]) if (wlog[i].a != 14'(i) || wlog[i].d != 8'h20) bad++;
        chk("init_content", bad, 0);
        chk("init_rdy_busy", busy_rdy, 0);
        chk("idle_ready0", bus.src0_ready, 1'b1);
        @(posedge clk48); #1;
        bus.src0_valid = 1'b0;
        chk("drop_no_write", bus.fb_wr_en, 1'b0);
        @(posedge clk48); #1;
        chk("drop_cursor", bus.cursor_addr, 14'd0);

        // Table vectors: printables, BS, CR, BS at col 0, dropped codes
        for (int i = 0; i < 9; i++) begin
            send(0, vecs[i].ch);
            chk("vec_wr_en", bus.fb_wr_en, vecs[i].wr);
            if (vecs[i].wr) begin
                chk("vec_waddr", bus.fb_waddr, vecs[i].addr);
                chk("vec_wdata", bus.fb_wdata, vecs[i].data);
            end
            @(posedge clk48); #1;
            chk("vec_cursor", bus.cursor_addr, vecs[i].cur);
        end

        // Line wrap: 81 printables from col 0
        send(0, 8'h0D);
        @(posedge clk48); #1;
        wlog.delete();
        for (int i = 0; i < 81; i++) begin
            ch = 8'h41 + 8'(i % 26);
            send(0, ch);
            if (i == 79) begin
                @(posedge clk48); #1;
                chk("wrap_busy", bus.busy, 1'b1);
            end
        end
        @(posedge clk48); #1;
        chk("wrap_count", wlog.size(), 161);
        bad = 0;
        foreach (wlog[i]) begin
            if (i < 80) begin
                if (wlog[i].a != 14'(i) || wlog[i].d != (8'h41 + 8'(i % 26))) bad++;
            end else if (i < 160) begin
                if (wlog[i].a != 14'(i) || wlog[i].d != 8'h20) bad++;
            end else begin
                if (wlog[i].a != 14'd80 || wlog[i].d != (8'h41 + 8'(80 % 26))) bad++;
            end
        end
        chk("wrap_content", bad, 0);
        chk("wrap_cursor", bus.cursor_addr, 14'd81);

        // Walk to row 29, then LF wraps to row 0 and clears it
        send(0, 8'h0D);
        for (int i = 0; i < 28; i++) send(0, 8'h0A);
        @(posedge clk48); #1;
        wait_not_busy(200);
        chk("row29_cursor", bus.cursor_addr, 14'd2320);
        wlog.delete();
        send(0, 8'h0A);
        @(posedge clk48); #1;
        wait_not_busy(200);
        chk("lf29_count", wlog.size(), 80);
        bad = 0;
        foreach (wlog[i]) if (wlog[i].a != 14'(i) || wlog[i].d != 8'h20) bad++;
        chk("lf29_content", bad, 0);
        chk("lf29_cursor", bus.cursor_addr, 14'd0);

        // Arbitration: both sources hold 8 bytes each
        wlog.delete();
        alog.delete();
        both_rdy = 0;
        fork
            begin
                for (int k = 0; k < 8; k++) send(0, 8'h61 + 8'(k));
            end
            begin
                for (int k = 0; k < 8; k++) send(1, 8'h30 + 8'(k));
            end
        join
        @(negedge clk48); #1;
        chk("arb_count", alog.size(), 16);
        chk("arb_wr_count", wlog.size(), 16);
        bad = 0;
        foreach (alog[i]) begin
            // Last accept before this burst came from src0, so src1 goes first
            s_exp = (i % 2 == 0);
            d_exp = s_exp ? (8'h30 + 8'(i / 2)) : (8'h61 + 8'(i / 2));
            if (alog[i].s != s_exp || alog[i].d != d_exp) bad++;
            if (i < wlog.size())
                if (wlog[i].a != 14'(i) || wlog[i].d != d_exp) bad++;
        end
        chk("arb_order", bad, 0);
        chk("arb_both_ready", both_rdy, 0);

        // Async reset in the middle of a row clear
        @(posedge clk48); #1;
        send(0, 8'h0A);
        @(posedge clk48); #1;
        @(posedge clk48); #1;
        chk("clear_active", bus.fb_wr_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_wr_en", bus.fb_wr_en, 1'b0);
        chk("async_waddr", bus.fb_waddr, 14'd0);
        chk("async_busy", bus.busy, 1'b1);
        chk("async_cursor", bus.cursor_addr, 14'd0);
        wlog.delete();
        @(posedge clk48); #3;
        rst_n = 1'b1;
        repeat (3) @(negedge clk48);
        #1;
        chk("reinit_count", (wlog.size() >= 3), 1'b1);
        bad = 0;
        foreach (wlog[i]) if (i < 3 && (wlog[i].a != 14'(i) || wlog[i].d != 8'h20)) bad++;
        chk("reinit_content", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
`default_nettype wire
